m216a_req_driver: RTL and testbench

Transmit-side front end for the strip-packing top module. Buffers rectangle requests (height, width) from an upstream valid/ready source and presents them to the packer's height_i/width_i on a fixed slot cadence, driving zero bubbles when no request is queued. It also captures the packer's placement (index_x, index_y, strike) a fixed number of slots later and returns it on a one-cycle result strobe.

---
 rtl/m216a_pkg.sv | 24 ++
 rtl/m216a_req_fifo.sv | 66 ++++++
 rtl/m216a_req_driver.sv | 128 ++++++++++++
 tb/tb_m216a_req_driver.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m216a_pkg.sv
// Shared widths and record types for the strip-packer request driver.
package m216a_pkg;

    localparam int DIM_W    = 5;
    localparam int IDX_W    = 8;
    localparam int STRIKE_W = 4;

    typedef struct packed {
        logic [DIM_W-1:0] height;
        logic [DIM_W-1:0] width;
    } req_t;

    typedef struct packed {
        logic [IDX_W-1:0]    index_x;
        logic [IDX_W-1:0]    index_y;
        logic [STRIKE_W-1:0] strike;
    } res_t;

    // A zero dimension is the packer's idle code, so it can never be a real request.
    function automatic logic is_bubble(input req_t r);
        return (r.height == '0) || (r.width == '0);
    endfunction

endpackage

// File: rtl/m216a_req_fifo.sv
// Request buffer: synchronous FIFO of req_t with first-word-fall-through head
// and registered full/empty flags.
module m216a_req_fifo
    import m216a_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  req_t data_i,
    input  logic pop_i,
    output req_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/m216a_req_driver.sv
// Slot-paced request driver for the strip packer with delayed placement capture.
// Optional strike-based issue halt is compiled in with `define M216A_STRIKE_STOP_EN.
module m216a_req_driver
    import m216a_pkg::*;
#(
    parameter int SLOT_CYCLES  = 4,
    parameter int RESULT_LAT   = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int STRIKE_LIMIT = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [DIM_W-1:0]    req_height_i,
    input  logic [DIM_W-1:0]    req_width_i,
    output logic [DIM_W-1:0]    height_o,
    output logic [DIM_W-1:0]    width_o,
    input  logic [IDX_W-1:0]    index_x_i,
    input  logic [IDX_W-1:0]    index_y_i,
    input  logic [STRIKE_W-1:0] strike_i,
    output logic                res_valid_o,
    output logic [IDX_W-1:0]    res_index_x_o,
    output logic [IDX_W-1:0]    res_index_y_o,
    output logic [STRIKE_W-1:0] res_strike_o,
    output logic [7:0]          drop_cnt_o,
    output logic                halted_o
);

    localparam int              CNT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

`ifdef M216A_STRIKE_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic [CNT_W-1:0]      cnt_q;
    logic [RESULT_LAT-1:0] inflight_q;
    logic [RESULT_LAT-1:0] inflight_d;
    req_t                  req_in;
    req_t                  head;
    req_t                  issue_q;
    res_t                  res_q;
    logic                  res_valid_q;
    logic                  ready_en_q;
    logic                  halted_q;
    logic [7:0]            drop_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  slot_start;
    logic                  slot_end;
    logic                  capture;

    assign req_in      = '{height: req_height_i, width: req_width_i};
    // ready_en_q holds ready low for the first cycle out of reset.
    assign req_ready_o = ready_en_q & ~fifo_full & ~halted_q;
    assign accept      = req_valid_i & req_ready_o;
    assign push        = accept & ~is_bubble(req_in);

    assign slot_start  = (cnt_q == '0);
    assign slot_end    = (cnt_q == SLOT_LAST);
    assign pop         = slot_start & ~fifo_empty & ~halted_q;

    // Bit 0 is the slot just issued; the oldest tracked slot sits at the top.
    always_comb begin
        inflight_d    = inflight_q << 1;
        inflight_d[0] = pop;
    end

    assign capture = slot_end & inflight_q[RESULT_LAT-1];

    m216a_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (req_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q       <= '0;
            inflight_q  <= '0;
            issue_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
            halted_q    <= 1'b0;
            drop_q      <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            cnt_q       <= slot_end ? '0 : cnt_q + 1'b1;
            res_valid_q <= capture;

            if (slot_start) begin
                issue_q    <= pop ? head : '0;
                inflight_q <= inflight_d;
            end

            if (capture) begin
                res_q <= '{index_x: index_x_i, index_y: index_y_i, strike: strike_i};
                if (STOP_EN && (strike_i >= STRIKE_W'(STRIKE_LIMIT))) halted_q <= 1'b1;
            end

            if (accept && is_bubble(req_in) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end

    assign height_o      = issue_q.height;
    assign width_o       = issue_q.width;
    assign res_valid_o   = res_valid_q;
    assign res_index_x_o = res_q.index_x;
    assign res_index_y_o = res_q.index_y;
    assign res_strike_o  = res_q.strike;
    assign drop_cnt_o    = drop_q;
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_m216a_req_driver.sv
// Self-checking bench for m216a_req_driver: a directed vector table, hand-written
// corner sequences and a randomized run scored against a time-based reference model.
module tb_m216a_req_driver;

    localparam int S     = 4;
    localparam int L     = 2;
    localparam int D     = 4;
    localparam int LIMIT = 3;

`ifdef M216A_STRIKE_STOP_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [4:0] req_height_i = '0;
    logic [4:0] req_width_i = '0;
    logic [4:0] height_o;
    logic [4:0] width_o;
    logic [7:0] index_x_i = '0;
    logic [7:0] index_y_i = '0;
    logic [3:0] strike_i = '0;
    logic       res_valid_o;
    logic [7:0] res_index_x_o;
    logic [7:0] res_index_y_o;
    logic [3:0] res_strike_o;
    logic [7:0] drop_cnt_o;
    logic       halted_o;

    always #5 clk_i = ~clk_i;

    m216a_req_driver #(
        .SLOT_CYCLES  (S),
        .RESULT_LAT   (L),
        .FIFO_DEPTH   (D),
        .STRIKE_LIMIT (LIMIT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_height_i  (req_height_i),
        .req_width_i   (req_width_i),
        .height_o      (height_o),
        .width_o       (width_o),
        .index_x_i     (index_x_i),
        .index_y_i     (index_y_i),
        .strike_i      (strike_i),
        .res_valid_o   (res_valid_o),
        .res_index_x_o (res_index_x_o),
        .res_index_y_o (res_index_y_o),
        .res_strike_o  (res_strike_o),
        .drop_cnt_o    (drop_cnt_o),
        .halted_o      (halted_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;
    int rv_cnt = 0;
    bit dut_acc;

    typedef struct {
        logic [4:0] h;
        logic [4:0] w;
    } rq_t;

    typedef struct {
        bit         v;
        logic [4:0] h, w;
        logic [7:0] px, py;
        logic [3:0] ps;
        logic [4:0] eh, ew;
        bit         erdy, erv;
        logic [7:0] erx, ery;
        logic [3:0] ers;
    } vec_t;

    // Reference model: FIFO as a queue, issue times in an array, results due L*S cycles after issue.
    rq_t        mq[$];
    bit         issued [4096];
    logic [4:0] m_h, m_w;
    bit         m_rv;
    logic [7:0] m_rx, m_ry;
    logic [3:0] m_rs;
    int         m_drop;
    bit         m_halted;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    function automatic logic [3:0] rnd_ps();
        if (STOP) return 4'($urandom_range(0, LIMIT - 1));
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic model_reset();
        mq.delete();
        issued   = '{default: 1'b0};
        m_h      = '0;
        m_w      = '0;
        m_rv     = 1'b0;
        m_rx     = '0;
        m_ry     = '0;
        m_rs     = '0;
        m_drop   = 0;
        m_halted = 1'b0;
        rv_cnt   = 0;
        k        = 0;
    endtask

    task automatic do_reset();
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        req_height_i = '0;
        req_width_i  = '0;
        #1;
        chk("rst_ready", req_ready_o, 0);
        chk("rst_height", height_o, 0);
        chk("rst_width", width_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_res_x", res_index_x_o, 0);
        chk("rst_res_y", res_index_y_o, 0);
        chk("rst_res_strike", res_strike_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_halted", halted_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        model_reset();
    endtask

    task automatic tick(input bit v, input logic [4:0] h, input logic [4:0] w,
                        input logic [7:0] px, input logic [7:0] py, input logic [3:0] ps);
        bit         ready_m;
        int         j;
        logic [4:0] nh, nw;
        rq_t        r;
        ready_m = (k >= 1) && (mq.size() < D) && !m_halted;
        chk("ready", req_ready_o, ready_m);
        chk("height", height_o, m_h);
        chk("width", width_o, m_w);
        chk("res_valid", res_valid_o, m_rv);
        chk("res_x", res_index_x_o, m_rx);
        chk("res_y", res_index_y_o, m_ry);
        chk("res_strike", res_strike_o, m_rs);
        chk("drop_cnt", drop_cnt_o, m_drop);
        chk("halted", halted_o, m_halted);
        rv_cnt += int'(res_valid_o);
        dut_acc = v && (req_ready_o === 1'b1);

        req_valid_i  = v;
        req_height_i = h;
        req_width_i  = w;
        index_x_i    = px;
        index_y_i    = py;
        strike_i     = ps;

        nh = m_h;
        nw = m_w;
        if (k % S == 0) begin
            if (mq.size() > 0 && !m_halted) begin
                r  = mq.pop_front();
                nh = r.h;
                nw = r.w;
                issued[k] = 1'b1;
            end else begin
                nh = '0;
                nw = '0;
            end
        end
        if (v && ready_m) begin
            if (h == 0 || w == 0) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
            else mq.push_back('{h: h, w: w});
        end
        j    = k + 1 - L * S;
        m_rv = (j >= 0) && issued[j];
        if (m_rv) begin
            m_rx = px;
            m_ry = py;
            m_rs = ps;
            if (STOP && ps >= LIMIT) m_halted = 1'b1;
        end
        m_h = nh;
        m_w = nw;
        @(posedge clk_i);
        #1;
        k++;
    endtask

    task automatic idle();
        tick(1'b0, 5'd0, 5'd0, 8'($urandom), 8'($urandom), rnd_ps());
    endtask

    initial begin
        vec_t tbl [18];
        rq_t  reqs [6];
        int   acc_cyc [6];
        int   idx;

        #2;
        do_reset();

        // Directed vectors: (3,5) then (4,8) with the packer answering (0,0) then (5,0).
        for (int i = 0; i < 18; i++) begin
            tbl[i].v   = 1'b0;
            tbl[i].h   = '0;
            tbl[i].w   = '0;
            tbl[i].px  = 8'h33;
            tbl[i].py  = 8'h44;
            tbl[i].ps  = 4'd2;
            tbl[i].eh  = (i >= 5 && i <= 8) ? 5'd3 : (i >= 9 && i <= 12) ? 5'd4 : 5'd0;
            tbl[i].ew  = (i >= 5 && i <= 8) ? 5'd5 : (i >= 9 && i <= 12) ? 5'd8 : 5'd0;
            tbl[i].erdy = (i >= 1);
            tbl[i].erv = (i == 12) || (i == 16);
            tbl[i].erx = (i >= 16) ? 8'd5 : 8'd0;
            tbl[i].ery = 8'd0;
            tbl[i].ers = (i >= 12) ? 4'd1 : 4'd0;
        end
        tbl[1].v = 1'b1; tbl[1].h = 5'd3; tbl[1].w = 5'd5;
        tbl[2].v = 1'b1; tbl[2].h = 5'd4; tbl[2].w = 5'd8;
        tbl[11].px = 8'd0; tbl[11].py = 8'd0; tbl[11].ps = 4'd1;
        tbl[15].px = 8'd5; tbl[15].py = 8'd0; tbl[15].ps = 4'd1;

        for (int i = 0; i < 18; i++) begin
            k = i;
            chk("tbl_ready", req_ready_o, tbl[i].erdy);
            chk("tbl_height", height_o, tbl[i].eh);
            chk("tbl_width", width_o, tbl[i].ew);
            chk("tbl_res_valid", res_valid_o, tbl[i].erv);
            chk("tbl_res_x", res_index_x_o, tbl[i].erx);
            chk("tbl_res_y", res_index_y_o, tbl[i].ery);
            chk("tbl_res_strike", res_strike_o, tbl[i].ers);
            req_valid_i  = tbl[i].v;
            req_height_i = tbl[i].h;
            req_width_i  = tbl[i].w;
            index_x_i    = tbl[i].px;
            index_y_i    = tbl[i].py;
            strike_i     = tbl[i].ps;
            @(posedge clk_i);
            #1;
        end

        // Idle after reset: bubbles only, no results.
        do_reset();
        repeat (20) idle();
        chk("idle_no_res", rv_cnt, 0);

        // Fill the buffer: the sixth request waits for a pop and only then gets in.
        do_reset();
        reqs = '{'{5'd1, 5'd2}, '{5'd3, 5'd4}, '{5'd5, 5'd6}, '{5'd7, 5'd8}, '{5'd9, 5'd10}, '{5'd11, 5'd12}};
        acc_cyc = '{default: -1};
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 6) begin
                tick(1'b1, reqs[idx].h, reqs[idx].w, 8'($urandom), 8'($urandom), rnd_ps());
                if (dut_acc) begin
                    acc_cyc[idx] = k - 1;
                    idx++;
                end
            end else begin
                idle();
            end
        end
        chk("full_accepted", idx, 6);
        chk("full_acc5_cycle", acc_cyc[4], 5);
        chk("full_acc6_cycle", acc_cyc[5], 9);
        chk("full_results", rv_cnt, 6);

        // Zero-dimension requests are handshaken and dropped.
        do_reset();
        idle();
        tick(1'b1, 5'd0, 5'd7, 8'($urandom), 8'($urandom), rnd_ps());
        tick(1'b1, 5'd6, 5'd0, 8'($urandom), 8'($urandom), rnd_ps());
        repeat (30) idle();
        chk("bubble_drop_cnt", drop_cnt_o, 2);
        chk("bubble_no_res", rv_cnt, 0);

        // Drop counter saturation.
        do_reset();
        idle();
        repeat (260) tick(1'b1, 5'd0, 5'($urandom), 8'($urandom), 8'($urandom), rnd_ps());
        chk("drop_saturate", drop_cnt_o, 255);

        // Reset mid-slot with two results in flight; nothing stale may appear afterwards.
        do_reset();
        idle();
        tick(1'b1, 5'd7, 5'd9, 8'($urandom), 8'($urandom), rnd_ps());
        tick(1'b1, 5'd2, 5'd3, 8'($urandom), 8'($urandom), rnd_ps());
        while (k < 10) idle();
        do_reset();
        repeat (30) idle();
        chk("stale_res", rv_cnt, 0);

`ifdef M216A_STRIKE_STOP_EN
        // Strike at the limit halts issue; the in-flight second request still reports.
        do_reset();
        idle();
        tick(1'b1, 5'd1, 5'd1, 8'($urandom), 8'($urandom), 4'd3);
        tick(1'b1, 5'd2, 5'd2, 8'($urandom), 8'($urandom), 4'd3);
        tick(1'b1, 5'd3, 5'd3, 8'($urandom), 8'($urandom), 4'd3);
        while (k < 26) tick(1'b0, 5'd0, 5'd0, 8'($urandom), 8'($urandom), 4'd3);
        chk("halt_flag", halted_o, 1);
        chk("halt_ready", req_ready_o, 0);
        chk("halt_results", rv_cnt, 2);
        chk("halt_height", height_o, 0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        repeat (400) begin
            bit         v;
            logic [4:0] h, w;
            v = 1'($urandom_range(0, 1));
            h = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            w = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            tick(v, h, w, 8'($urandom), 8'($urandom), rnd_ps());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
